phy_tx_serializer: RTL and testbench

- Transmit-side PHY datapath; the counterpart of the PHY receive chain.
- Accepts four 8-bit lanes with per-lane valids once per 32-bit frame, byte-interleaves them (lane0..lane3) and shifts them out MSB-first on one serial line.
- Empty or invalid slots carry the COM/idle character 0xBC, so the far-end serial-to-parallel stage can lock and decode valids.
- Runs entirely on clk_32f; the f/4f phases come from an internal frame counter instead of derived clocks.

---
 rtl/phy_tx_serializer_if.sv | 27 ++
 rtl/phy_tx_serializer.sv | 103 ++++++++++
 tb/tb_phy_tx_serializer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/phy_tx_serializer_if.sv
// Lane-side bus of the transmit serializer: four data bytes with valids, enable and the sample strobe.
// No latency of its own; the serializer samples the lanes in the single cycle in_ready is high.
// The producer holds lanes stable until in_ready; lanes not sampled are simply not consumed.
interface phy_tx_serializer_if;
  logic       tx_enable;
  logic [7:0] in0;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [7:0] in3;
  logic       valid_in0;
  logic       valid_in1;
  logic       valid_in2;
  logic       valid_in3;
  logic       in_ready;

  modport master (
    output tx_enable, in0, in1, in2, in3,
    output valid_in0, valid_in1, valid_in2, valid_in3,
    input  in_ready
  );

  modport slave (
    input  tx_enable, in0, in1, in2, in3,
    input  valid_in0, valid_in1, valid_in2, valid_in3,
    output in_ready
  );
endinterface

// File: rtl/phy_tx_serializer.sv
// Byte-interleaves four lanes into a 32-bit frame and shifts it out MSB-first, COM-filling empty slots.
// Latency: a lane sampled with in_ready starts driving on the next cycle; lane3 bit0 leaves 32 cycles later.
// Backpressure: in_ready pulses once per frame only when synced and tx_enable; otherwise all-COM frames go out.
module phy_tx_serializer #(
  parameter logic [7:0]  COM_CHAR    = 8'hBC,
  parameter int unsigned SYNC_FRAMES = 2
) (
  input  logic                  clk_32f,
  input  logic                  reset_L,
  phy_tx_serializer_if.slave    lanes,
  output logic                  serial_out,
  output logic                  tx_active,
  output logic                  synced
);

  typedef enum logic {SYNC, ACTIVE} state_t;

  localparam logic [3:0] SYNC_TARGET = 4'(SYNC_FRAMES);

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  frame_cnt;
  logic [31:0] frame_buf;
  logic [3:0]  sync_cnt;
  logic        frame_end;
  logic [4:0]  bit_sel;
  logic [3:0]  lane_take;
  logic [31:0] new_frame;

  assign frame_end = (frame_cnt == 5'd31);
  // Next bit to present: frame_buf[31-(k+1)] while a frame is in flight.
  assign bit_sel   = 5'd30 - frame_cnt;

  // Per-lane capture decision and the frame to load at the boundary; empty slots carry COM.
  always_comb begin
    lane_take = {lanes.in_ready & lanes.valid_in0,
                 lanes.in_ready & lanes.valid_in1,
                 lanes.in_ready & lanes.valid_in2,
                 lanes.in_ready & lanes.valid_in3};
    new_frame = {4{COM_CHAR}};
    if (lane_take[3]) new_frame[31:24] = lanes.in0;
    if (lane_take[2]) new_frame[23:16] = lanes.in1;
    if (lane_take[1]) new_frame[15:8]  = lanes.in2;
    if (lane_take[0]) new_frame[7:0]   = lanes.in3;
  end

  // Free-running bit position within the frame; the 31->0 wrap is the only frame boundary.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      frame_cnt <= 5'd0;
    end else begin
      frame_cnt <= frame_cnt + 5'd1;
    end
  end

  // Frame buffer, serial line and activity flag; the first bit of a new frame is loaded with the frame.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      frame_buf  <= {4{COM_CHAR}};
      serial_out <= COM_CHAR[7];
      tx_active  <= 1'b0;
    end else if (frame_end) begin
      frame_buf  <= new_frame;
      serial_out <= new_frame[31];
      tx_active  <= |lane_take;
    end else begin
      serial_out <= frame_buf[bit_sel];
    end
  end

  // Count COM frames sent during sync; frozen once active so it can never wrap.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      sync_cnt <= 4'd0;
    end else if ((state == SYNC) && frame_end) begin
      sync_cnt <= sync_cnt + 4'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state <= SYNC;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: leave SYNC on the boundary that completes the last sync frame; ACTIVE is sticky.
  always_comb begin
    state_nxt = state;
    if ((state == SYNC) && frame_end && ((sync_cnt + 4'd1) == SYNC_TARGET)) begin
      state_nxt = ACTIVE;
    end
  end

  // FSM outputs: sync status and the once-per-frame sample strobe.
  always_comb begin
    synced         = (state == ACTIVE);
    lanes.in_ready = frame_end && (state == ACTIVE) && lanes.tx_enable;
  end

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Self-checking bench for phy_tx_serializer: frame-level model checked every cycle plus directed literals.
// Stimulus changes just after a falling edge; DUT outputs are sampled on falling edges.
// Every wait for in_ready is bounded and a timeout counts as a failure.
module tb_phy_tx_serializer;
  localparam logic [7:0] COM  = 8'hBC;
  localparam int         SYNC = 2;

  logic clk_32f = 1'b0;
  logic reset_L = 1'b0;
  logic serial_out, tx_active, synced;

  phy_tx_serializer_if lanes_if();

  phy_tx_serializer #(.COM_CHAR(COM), .SYNC_FRAMES(SYNC)) dut (
    .clk_32f    (clk_32f),
    .reset_L    (reset_L),
    .lanes      (lanes_if),
    .serial_out (serial_out),
    .tx_active  (tx_active),
    .synced     (synced)
  );

  always #5 clk_32f = ~clk_32f;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  // cyc counts cycles since reset release; frame f = cyc/32, bit k = cyc%32.
  // Frames 0..SYNC are sync/COM frames; sampling is possible at k==31 of any frame f >= SYNC.
  int          cyc = 0;
  int          bnd_f = 0;
  bit          bnd = 1'b0;
  logic [31:0] m_frame = {4{COM}};
  bit          m_active = 1'b0;

  always @(negedge clk_32f) begin
    int k, f;
    bit exp_rdy;
    if (!reset_L) begin
      check("rst_serial_out", serial_out, 1'b1);
      check("rst_tx_active", tx_active, 1'b0);
      check("rst_in_ready", lanes_if.in_ready, 1'b0);
      check("rst_synced", synced, 1'b0);
      cyc = 0;
      bnd = 1'b0;
      m_frame = {4{COM}};
      m_active = 1'b0;
    end else begin
      k = cyc % 32;
      f = cyc / 32;
      exp_rdy = (k == 31) && (f >= SYNC) && lanes_if.tx_enable;
      check("serial_out", serial_out, m_frame[31-k]);
      check("tx_active", tx_active, m_active);
      check("synced", synced, f >= SYNC);
      check("in_ready", lanes_if.in_ready, exp_rdy);
      bnd = (k == 31);
      bnd_f = f;
      cyc++;
    end
  end

  always @(posedge clk_32f) begin
    bit rdy;
    logic [3:0] tk;
    if (reset_L && bnd) begin
      rdy = (bnd_f >= SYNC) && lanes_if.tx_enable;
      tk = {rdy && lanes_if.valid_in0, rdy && lanes_if.valid_in1,
            rdy && lanes_if.valid_in2, rdy && lanes_if.valid_in3};
      m_frame = {tk[3] ? lanes_if.in0 : COM, tk[2] ? lanes_if.in1 : COM,
                 tk[1] ? lanes_if.in2 : COM, tk[0] ? lanes_if.in3 : COM};
      m_active = |tk;
      bnd = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready(output int n);
    n = 0;
    while (!lanes_if.in_ready && n < 400) begin
      @(negedge clk_32f);
      n++;
    end
    if (!lanes_if.in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_ready: in_ready not seen after %0d cycles", n);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] v);
    lanes_if.in0 = d[31:24];
    lanes_if.in1 = d[23:16];
    lanes_if.in2 = d[15:8];
    lanes_if.in3 = d[7:0];
    {lanes_if.valid_in0, lanes_if.valid_in1, lanes_if.valid_in2, lanes_if.valid_in3} = v;
  endtask

  task automatic grab(input int n, output logic [127:0] w);
    w = '0;
    repeat (n) begin
      @(negedge clk_32f);
      w = {w[126:0], serial_out};
    end
  endtask

  initial begin
    int n;
    logic [127:0] w;
    lanes_if.tx_enable = 1'b1;
    drive(32'h0, 4'b0000);

    repeat (3) @(posedge clk_32f);
    #1 reset_L = 1'b1;

    // Sync: three COM frames then the first strobe at cycle 95.
    wait_ready(n);
    check("first_ready_cycles", n, 96);
    check("synced_at_first_ready", synced, 1'b1);

    // All lanes valid.
    #1 drive(32'h12345678, 4'b1111);
    grab(32, w);
    check("frame_12345678", w[31:0], 32'h12345678);

    // Valid pattern 1010.
    wait_ready(n);
    #1 drive(32'hAAFF5500, 4'b1010);
    grab(32, w);
    check("frame_valid_1010", w[31:0], 32'hAABC55BC);

    // tx_enable low at the boundary with valids high.
    wait_ready(n);
    #1 lanes_if.tx_enable = 1'b0;
    drive(32'h11223344, 4'b1111);
    grab(32, w);
    check("frame_disabled", w[31:0], 32'hBCBCBCBC);
    check("disabled_no_ready", lanes_if.in_ready, 1'b0);

    // Raise tx_enable mid-frame: capture only at the next boundary.
    repeat (10) @(negedge clk_32f);
    #1 lanes_if.tx_enable = 1'b1;
    wait_ready(n);
    check("reenable_ready_cycles", n, 22);
    grab(32, w);
    check("frame_reenabled", w[31:0], 32'h11223344);

    // Back-to-back frames: continuous 128-bit stream.
    w = '0;
    for (int i = 0; i < 4; i++) begin
      logic [127:0] part;
      logic [7:0] b;
      wait_ready(n);
      check("b2b_no_gap", n, 0);
      b = 8'((i + 1) * 16);
      #1 drive({b, b + 8'd1, b + 8'd2, b + 8'd3}, 4'b1111);
      grab(32, part);
      w = {w[95:0], part[31:0]};
    end
    check("b2b_stream", w, 128'h10111213_20212223_30313233_40414243);

    // Mid-frame reset at frame_cnt=13 of an all-zero data frame.
    wait_ready(n);
    #1 drive(32'h00000000, 4'b1111);
    repeat (14) @(posedge clk_32f);
    #2;
    check("pre_reset_bit", serial_out, 1'b0);
    check("pre_reset_active", tx_active, 1'b1);
    reset_L = 1'b0;
    #1;
    check("async_serial_out", serial_out, 1'b1);
    check("async_tx_active", tx_active, 1'b0);
    check("async_synced", synced, 1'b0);
    repeat (2) @(posedge clk_32f);
    #1 reset_L = 1'b1;
    wait_ready(n);
    check("resync_ready_cycles", n, 96);
    #1 drive(32'hA1B2C3D4, 4'b1111);
    grab(32, w);
    check("frame_after_reset", w[31:0], 32'hA1B2C3D4);

    repeat (3) @(negedge clk_32f);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
